// File: rtl/nx_stream_skid_fifo.sv
// Multi-entry stream skid FIFO with optional fall-through when empty.
// Optional high-water mark output: define NX_STREAM_SKID_FIFO_WATERMARK_EN.
module nx_stream_skid_fifo #(
    parameter int STREAM_WIDTH = 32,
    parameter int DEPTH        = 4,
    parameter bit BYPASS       = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [STREAM_WIDTH-1:0]    inbound_data_i,
    input  logic                       inbound_valid_i,
    output logic                       inbound_ready_o,
    output logic [STREAM_WIDTH-1:0]    outbound_data_o,
    output logic                       outbound_valid_o,
    input  logic                       outbound_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       full_o,
`ifdef NX_STREAM_SKID_FIFO_WATERMARK_EN
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] hwm_o
`else
    output logic                       empty_o
`endif
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [STREAM_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]           rd_ptr;
    logic [PW-1:0]           wr_ptr;
    logic [LW-1:0]           level_q;
    logic [LW-1:0]           level_next;
    logic                    empty;
    logic                    full;
    logic                    in_fire;
    logic                    out_fire;
    logic                    pass;
    logic                    wr_en;
    logic                    rd_en;

    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));

    // Ready comes from registered level only; no path from outbound_ready_i.
    assign inbound_ready_o = !full && !rst_i;

    always_comb begin
        outbound_data_o  = mem[rd_ptr];
        outbound_valid_o = 1'b0;
        if (rst_i) begin
            outbound_valid_o = 1'b0;
        end else if (!empty) begin
            outbound_valid_o = 1'b1;
        end else if (BYPASS) begin
            outbound_data_o  = inbound_data_i;
            outbound_valid_o = inbound_valid_i;
        end
    end

    assign in_fire  = inbound_valid_i && inbound_ready_o;
    assign out_fire = outbound_valid_o && outbound_ready_i;
    assign pass     = BYPASS && empty && in_fire && outbound_ready_i;
    assign wr_en    = in_fire && !pass;
    assign rd_en    = out_fire && !empty;

    assign level_next = level_q + LW'(wr_en) - LW'(rd_en);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            level_q <= level_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= inbound_data_i;
        end
    end

    assign level_o = level_q;
    assign full_o  = full;
    assign empty_o = empty;

`ifdef NX_STREAM_SKID_FIFO_WATERMARK_EN
    logic [LW-1:0] hwm_q;

    // level_next never exceeds DEPTH, so the mark saturates there.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hwm_q <= '0;
        end else if (level_next > hwm_q) begin
            hwm_q <= level_next;
        end
    end

    assign hwm_o = hwm_q;
`endif

endmodule

// File: tb/tb_nx_stream_skid_fifo.sv
// Bench for nx_stream_skid_fifo: three configurations against a queue model.
// Covers bypass, registered, odd depth, reset and (optionally) watermark.
module tb_nx_stream_skid_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        vld;
    logic        ordy;
    logic [31:0] dat;

    logic        rdy0, rdy1, rdy2;
    logic        ov0, ov1, ov2;
    logic        fl0, fl1, fl2;
    logic        em0, em1, em2;
    logic [31:0] od0, od1, od2;
    logic [2:0]  lvl0, lvl1;
    logic [1:0]  lvl2;
`ifdef NX_STREAM_SKID_FIFO_WATERMARK_EN
    logic [2:0]  hwm0, hwm1;
    logic [1:0]  hwm2;
`endif

    int total = 0;
    int bad = 0;

    logic [31:0] mq [3][$];
    int          mh [3];
    int          md [3] = '{4, 4, 3};
    bit          mb [3] = '{1'b1, 1'b0, 1'b0};

    nx_stream_skid_fifo #(.STREAM_WIDTH(32), .DEPTH(4), .BYPASS(1'b1)) u0 (
        .clk_i(clk), .rst_i(rst),
        .inbound_data_i(dat), .inbound_valid_i(vld), .inbound_ready_o(rdy0),
        .outbound_data_o(od0), .outbound_valid_o(ov0), .outbound_ready_i(ordy),
        .level_o(lvl0), .full_o(fl0),
`ifdef NX_STREAM_SKID_FIFO_WATERMARK_EN
        .empty_o(em0), .hwm_o(hwm0)
`else
        .empty_o(em0)
`endif
    );

    nx_stream_skid_fifo #(.STREAM_WIDTH(32), .DEPTH(4), .BYPASS(1'b0)) u1 (
        .clk_i(clk), .rst_i(rst),
        .inbound_data_i(dat), .inbound_valid_i(vld), .inbound_ready_o(rdy1),
        .outbound_data_o(od1), .outbound_valid_o(ov1), .outbound_ready_i(ordy),
        .level_o(lvl1), .full_o(fl1),
`ifdef NX_STREAM_SKID_FIFO_WATERMARK_EN
        .empty_o(em1), .hwm_o(hwm1)
`else
        .empty_o(em1)
`endif
    );

    nx_stream_skid_fifo #(.STREAM_WIDTH(32), .DEPTH(3), .BYPASS(1'b0)) u2 (
        .clk_i(clk), .rst_i(rst),
        .inbound_data_i(dat), .inbound_valid_i(vld), .inbound_ready_o(rdy2),
        .outbound_data_o(od2), .outbound_valid_o(ov2), .outbound_ready_i(ordy),
        .level_o(lvl2), .full_o(fl2),
`ifdef NX_STREAM_SKID_FIFO_WATERMARK_EN
        .empty_o(em2), .hwm_o(hwm2)
`else
        .empty_o(em2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, check all DUTs vs model, advance model.
    task automatic step(input logic v, input logic [31:0] d, input logic r,
                        input logic rs, output logic [2:0] acc);
        logic        g_rdy [3];
        logic        g_ov  [3];
        logic        g_fl  [3];
        logic        g_em  [3];
        logic [31:0] g_od  [3];
        int          g_lvl [3];
        logic        e_rdy [3];
        logic        e_ov  [3];
        vld  = v;
        dat  = d;
        ordy = r;
        rst  = rs;
        #1;
        g_rdy = '{rdy0, rdy1, rdy2};
        g_ov  = '{ov0, ov1, ov2};
        g_fl  = '{fl0, fl1, fl2};
        g_em  = '{em0, em1, em2};
        g_od  = '{od0, od1, od2};
        g_lvl = '{int'(lvl0), int'(lvl1), int'(lvl2)};
        for (int k = 0; k < 3; k++) begin
            int cnt;
            cnt = mq[k].size();
            e_rdy[k] = !rs && (cnt < md[k]);
            e_ov[k]  = !rs && ((cnt > 0) || (mb[k] && v));
            acc[k]   = e_rdy[k] && v;
            check($sformatf("ready%0d", k), 32'(g_rdy[k]), 32'(e_rdy[k]));
            check($sformatf("valid%0d", k), 32'(g_ov[k]), 32'(e_ov[k]));
            check($sformatf("level%0d", k), g_lvl[k], cnt);
            check($sformatf("full%0d", k), 32'(g_fl[k]), 32'(cnt == md[k]));
            check($sformatf("empty%0d", k), 32'(g_em[k]), 32'(cnt == 0));
            if (e_ov[k]) begin
                check($sformatf("data%0d", k), g_od[k],
                      (cnt > 0) ? mq[k][0] : d);
            end
        end
`ifdef NX_STREAM_SKID_FIFO_WATERMARK_EN
        check("hwm0", 32'(hwm0), mh[0]);
        check("hwm1", 32'(hwm1), mh[1]);
        check("hwm2", 32'(hwm2), mh[2]);
`endif
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            int  cnt;
            bit  in_ok;
            bit  out_ok;
            if (rs) begin
                mq[k].delete();
                mh[k] = 0;
            end else begin
                cnt    = mq[k].size();
                in_ok  = v && e_rdy[k];
                out_ok = e_ov[k] && r;
                if (!(cnt == 0 && mb[k] && in_ok && r)) begin
                    if (out_ok) void'(mq[k].pop_front());
                    if (in_ok) mq[k].push_back(d);
                end
                if (mq[k].size() > mh[k]) mh[k] = mq[k].size();
            end
        end
        @(negedge clk);
    endtask

    logic [2:0] acc;
    int         n;
    int         i;
    bit         sent;

    initial begin
        rst  = 1'b1;
        vld  = 1'b0;
        dat  = '0;
        ordy = 1'b0;
        mh   = '{0, 0, 0};
        repeat (2) @(posedge clk);
        @(negedge clk);

        // reset state
        step(1'b0, 32'h0, 1'b0, 1'b1, acc);

        // bypass pass-through, same cycle
        step(1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, acc);
        check("t1_level", 32'(lvl0), 32'd0);

        // fill registered DUT, fifth beat held
        for (int b = 1; b <= 4; b++) step(1'b1, b, 1'b0, 1'b0, acc);
        check("t2_full", 32'(fl1), 32'd1);
        check("t2_ready", 32'(rdy1), 32'd0);
        step(1'b1, 32'h5, 1'b0, 1'b0, acc);
        check("t2_hold", 32'(lvl1), 32'd4);

        // drain in order, 0x5 accepted after first pop
        sent = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step(!sent, 32'h5, 1'b1, 1'b0, acc);
            if (acc[1]) sent = 1'b1;
        end
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0, acc);
        check("t3_empty", 32'(em1), 32'd1);

        // depth 3 wrap with toggling ready
        step(1'b0, 32'h0, 1'b0, 1'b1, acc);
        n = 0;
        i = 0;
        while (n < 10 && i < 200) begin
            step(1'b1, n, (i % 2) == 0, 1'b0, acc);
            if (acc[2]) n++;
            i++;
        end
        check("t4_sent", n, 10);
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b0, acc);
        check("t4_empty", 32'(em2), 32'd1);

        // reset mid-operation
        for (int b = 0; b < 3; b++) step(1'b1, 32'h100 + b, 1'b0, 1'b0, acc);
        step(1'b0, 32'h0, 1'b0, 1'b1, acc);
        check("t5_level", 32'(lvl1), 32'd0);
        check("t5_empty", 32'(em1), 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b1, acc);
        step(1'b0, 32'h0, 1'b1, 1'b0, acc);
        check("t5_ready", 32'(rdy1), 32'd1);
        check("t5_stale", 32'(ov1), 32'd0);

        // watermark: fill 3, drain, refill 1, reset
        for (int b = 0; b < 3; b++) step(1'b1, 32'h200 + b, 1'b0, 1'b0, acc);
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0, acc);
        step(1'b1, 32'h300, 1'b0, 1'b0, acc);
`ifdef NX_STREAM_SKID_FIFO_WATERMARK_EN
        check("t6_hwm", 32'(hwm1), 32'd3);
`endif
        step(1'b0, 32'h0, 1'b0, 1'b1, acc);
`ifdef NX_STREAM_SKID_FIFO_WATERMARK_EN
        check("t6_hwm_rst", 32'(hwm1), 32'd0);
`endif

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 3) != 0, $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0, acc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
